// File: rtl/smol_pkg.sv
// smol_pkg: shared decode types and RV32I base opcodes for smolCore.
package smol_pkg;
   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_R    = 3'd1,
      FMT_I    = 3'd2,
      FMT_S    = 3'd3,
      FMT_B    = 3'd4,
      FMT_U    = 3'd5,
      FMT_J    = 3'd6
   } fmt_e;

   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
endpackage

// File: rtl/smol_imm_gen.sv
// smol_imm_gen: classifies the opcode into an encoding format and builds the sign-extended immediate.
module smol_imm_gen
   import smol_pkg::*;
(
   input  logic [31:0] instr,
   output fmt_e        fmt,
   output logic [31:0] imm
);
   always_comb begin
      case (instr[6:0])
         OPC_OP:                                                  fmt = FMT_R;
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_I;
         OPC_STORE:                                               fmt = FMT_S;
         OPC_BRANCH:                                              fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:                                      fmt = FMT_U;
         OPC_JAL:                                                 fmt = FMT_J;
         default:                                                 fmt = FMT_NONE;
      endcase
   end

   always_comb begin
      case (fmt)
         FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm = {instr[31:12], 12'h000};
         FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end
endmodule

// File: rtl/smol_ins_dec.sv
// smol_ins_dec: registered RV32I instruction decoder (fields, immediate, format, legality).
// SMOL_INSDEC_ILLEGAL_EN builds the illegal-opcode flag; otherwise illegal is tied to 0.
module smol_ins_dec
   import smol_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   output logic [6:0]  opcode,
   output logic [4:0]  rd,
   output logic [2:0]  funct3,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [6:0]  funct7,
   output logic [31:0] imm,
   output fmt_e        fmt,
   output logic        illegal
);
   fmt_e        fmt_c;
   logic [31:0] imm_c;

   smol_imm_gen u_imm_gen (
      .instr (instr),
      .fmt   (fmt_c),
      .imm   (imm_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode <= '0;
         rd     <= '0;
         funct3 <= '0;
         rs1    <= '0;
         rs2    <= '0;
         funct7 <= '0;
         imm    <= '0;
         fmt    <= FMT_NONE;
      end else begin
         opcode <= instr[6:0];
         rd     <= instr[11:7];
         funct3 <= instr[14:12];
         rs1    <= instr[19:15];
         rs2    <= instr[24:20];
         funct7 <= instr[31:25];
         imm    <= imm_c;
         fmt    <= fmt_c;
      end
   end

`ifdef SMOL_INSDEC_ILLEGAL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal <= 1'b0;
      else        illegal <= (fmt_c == FMT_NONE);
   end
`else
   assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_smol_ins_dec.sv
// tb_smol_ins_dec: random and directed decode checks against a field-level reference model via a scoreboard queue.
module tb_smol_ins_dec;
   import smol_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] imm;
   fmt_e        fmt;
   logic        illegal;

   int total = 0;
   int bad = 0;
   logic [67:0] exp_q[$];

   smol_ins_dec dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .instr   (instr),
      .opcode  (opcode),
      .rd      (rd),
      .funct3  (funct3),
      .rs1     (rs1),
      .rs2     (rs2),
      .funct7  (funct7),
      .imm     (imm),
      .fmt     (fmt),
      .illegal (illegal)
   );

   always #5 clk = ~clk;

   logic [6:0] opc_tab [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
   logic [31:0] directed [8] = '{32'hFFF00093, 32'h0020A423, 32'h123452B7, 32'hFFDFF06F,
                                 32'hAAAABBBB, 32'h00000000, 32'h12345678, 32'hFE000EE3};

   // Reference: pick format from the opcode, gather the scattered immediate bits, then sign-extend by width.
   function automatic logic [67:0] ref_dec(input logic [31:0] w);
      int f;
      int raw;
      int width;
      logic [31:0] im;
      logic ill;
      f = 0; raw = 0; width = 32;
      case (w[6:0])
         7'h33: f = 1;
         7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin f = 2; raw = 32'(w[31:20]); width = 12; end
         7'h23: begin f = 3; raw = 32'({w[31:25], w[11:7]}); width = 12; end
         7'h63: begin f = 4; raw = 32'({w[31], w[7], w[30:25], w[11:8], 1'b0}); width = 13; end
         7'h37, 7'h17: begin f = 5; raw = int'(w & 32'hFFFFF000); end
         7'h6F: begin f = 6; raw = 32'({w[31], w[19:12], w[20], w[30:21], 1'b0}); width = 21; end
         default: f = 0;
      endcase
      im = 32'((raw <<< (32 - width)) >>> (32 - width));
`ifdef SMOL_INSDEC_ILLEGAL_EN
      ill = (f == 0);
`else
      ill = 1'b0;
`endif
      return {w[6:0], w[11:7], w[14:12], w[19:15], w[24:20], w[31:25], im, 3'(f), ill};
   endfunction

   function automatic logic [67:0] actual();
      return {opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, illegal};
   endfunction

   task automatic check(input string name, input logic [67:0] got, input logic [67:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic send(input logic [31:0] w);
      @(negedge clk);
      instr = w;
      exp_q.push_back(ref_dec(w));
   endtask

   always begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) check("decode", actual(), exp_q.pop_front());
   end

   initial begin
      logic [31:0] w;
      instr = 32'hFFF00093;
      repeat (2) @(negedge clk);
      check("reset_hold", actual(), '0);
      @(posedge clk);
      #1;
      check("reset_edge", actual(), '0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(ref_dec(instr));
      foreach (directed[i]) send(directed[i]);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_async", actual(), '0);
      @(posedge clk);
      #1;
      check("reset_mid", actual(), '0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(ref_dec(instr));
      for (int n = 0; n < 300; n++) begin
         w = $urandom;
         if ($urandom_range(0, 3) != 0) w[6:0] = opc_tab[$urandom_range(0, 10)];
         send(w);
      end
      repeat (3) @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
